// File: rtl/reset_sequencer.sv
// Reset sequencer: merges POR, watchdog, trap, software and pin resets into a
// staggered peripheral/CPU reset release, with a sticky cause log and counter.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wdt_req,
    input  logic       trap_req,
    input  logic       sw_req,
    input  logic       ext_reset_n,
    input  logic       cause_clear,
    input  logic [7:0] cause_wdata,
    output logic       sys_reset,
    output logic       periph_reset,
    output logic [7:0] cause_out,
    output logic [7:0] reset_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        POR_HOLD,
        HOLD,
        STAGGER,
        RUN
    } state_e;

    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STAGGER_LAST = 8'(STAGGER_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cause_q, cause_d;
    logic [7:0] count_q, count_d;
    logic [1:0] sync_q, sync_d;
    logic       sys_q, sys_d;
    logic       periph_q, periph_d;
    logic       busy_q, busy_d;

    logic       ext_req;
    logic       req;
    logic [7:0] src;

    assign ext_req = ~sync_q[1];
    assign req     = wdt_req | trap_req | sw_req | ext_req;
    assign src     = {3'b000, ext_req, sw_req, trap_req, wdt_req, 1'b0};
    assign sync_d  = {sync_q[0], ext_reset_n};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            POR_HOLD, HOLD: begin
                cause_d = cause_q | src;
                if (req) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = STAGGER;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STAGGER: begin
                cause_d = cause_q | src;
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                end else if (cnt_q == STAGGER_LAST) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RUN: begin
                // A new reset replaces the log, so it also overrides a clear
                if (req) begin
                    state_d = HOLD;
                    cnt_d   = 8'd0;
                    cause_d = src;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end else if (cause_clear) begin
                    cause_d = cause_q & ~cause_wdata;
                end
            end
        endcase
        cause_d[7:5] = 3'b000;
        sys_d    = (state_d != RUN);
        periph_d = (state_d == POR_HOLD) || (state_d == HOLD);
        busy_d   = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= POR_HOLD;
            cnt_q    <= 8'd0;
            cause_q  <= 8'h01;
            count_q  <= 8'd0;
            sync_q   <= 2'b11;
            sys_q    <= 1'b1;
            periph_q <= 1'b1;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            sync_q   <= sync_d;
            sys_q    <= sys_d;
            periph_q <= periph_d;
            busy_q   <= busy_d;
        end
    end

    assign sys_reset    = sys_q;
    assign periph_reset = periph_q;
    assign busy         = busy_q;
    assign cause_out    = cause_q;
    assign reset_count  = count_q;

endmodule
